// File: rtl/i4004_bus_ctrl.sv
// i4004_bus_ctrl: two-phase clock / POC generator and opcode fetch bridge for the i4004 core.
// Build option BUS_STALL_EN: a late mem_ack freezes A3 seg3 instead of forcing a NOP.
module i4004_bus_ctrl #(
  parameter int DIV        = 2,
  parameter int POC_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        clk1_out,
  output logic        clk2_out,
  output logic        poc_out,
  input  logic        sync_in,
  input  logic        cmrom_in,
  input  logic [3:0]  cpu_data,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        locked,
  output logic        err
);
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} sub_t;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_END = TW'(DIV - 1);
  sub_t          r_sub;
  logic [1:0]    r_seg;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_poc_cnt;
  logic [7:0]    r_op;
  logic          r_valid;
  logic          r_late;
  logic          w_tick_end;
  logic          w_smp;
  logic          w_deadline;
  logic          w_pending;
  logic          w_sync_bad;
  logic          w_wrap;
  logic          w_freeze;
  logic          w_late;
  assign w_tick_end = r_tick == TICK_END;
  assign w_smp      = w_tick_end && r_seg == 2'd2;
  assign w_deadline = w_tick_end && r_seg == 2'd3 && r_sub == A3;
  assign w_wrap     = w_tick_end && r_seg == 2'd3 && r_sub == X3;
  assign w_pending  = mem_req && !mem_ack;
  assign w_sync_bad = w_smp && sync_in && r_sub != X3;
`ifdef BUS_STALL_EN
  assign w_freeze = w_deadline && w_pending;
  assign w_late   = 1'b0;
`else
  assign w_freeze = 1'b0;
  assign w_late   = w_deadline && w_pending;
`endif
  // Outputs are registered from the counter, so pads trail the counter by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub     <= A1;
      r_seg     <= '0;
      r_tick    <= '0;
      r_poc_cnt <= '0;
      r_op      <= '0;
      r_valid   <= 1'b0;
      r_late    <= 1'b0;
      clk1_out  <= 1'b0;
      clk2_out  <= 1'b0;
      poc_out   <= 1'b1;
      data_out  <= '0;
      data_oe   <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      clk1_out <= r_seg == 2'd0;
      clk2_out <= r_seg == 2'd2;
      data_oe  <= r_valid && (r_sub == M1 || r_sub == M2);
      data_out <= !r_valid ? 4'h0 : r_sub == M1 ? r_op[7:4] : r_sub == M2 ? r_op[3:0] : 4'h0;
      if (w_sync_bad) begin
        r_sub  <= X3;
        r_seg  <= 2'd2;
        r_tick <= '0;
      end else if (!w_freeze) begin
        r_tick <= w_tick_end ? '0 : r_tick + TW'(1);
        if (w_tick_end) r_seg <= r_seg + 2'd1;
        if (w_tick_end && r_seg == 2'd3) r_sub <= sub_t'(r_sub + 3'd1);
      end
      if (w_smp && r_sub == X3) locked <= sync_in;
      if (w_sync_bad) begin
        locked <= 1'b0;
        err    <= 1'b1;
      end
      if (w_wrap && poc_out) begin
        r_poc_cnt <= r_poc_cnt + 8'd1;
        if (r_poc_cnt == 8'(POC_CYCLES - 1)) poc_out <= 1'b0;
      end
      // Address is frozen while a request (possibly a late one) is outstanding.
      if (w_smp && !mem_req) begin
        if (r_sub == A1) mem_addr[3:0]  <= cpu_data;
        if (r_sub == A2) mem_addr[7:4]  <= cpu_data;
        if (r_sub == A3) mem_addr[11:8] <= cpu_data;
        if (r_sub == A3 && cmrom_in && !poc_out) begin
          mem_req <= 1'b1;
          r_late  <= 1'b0;
        end
      end
      if (r_sub == X1) r_valid <= 1'b0;
      if (w_late) begin
        r_late  <= 1'b1;
        r_op    <= 8'h00;
        r_valid <= 1'b1;
        err     <= 1'b1;
      end
      if (mem_ack && !mem_req) err <= 1'b1;
      if (mem_ack && mem_req) begin
        mem_req <= 1'b0;
        r_late  <= 1'b0;
        if (!r_late) begin
          r_op    <= mem_data;
          r_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i4004_bus_ctrl.sv
// tb_i4004_bus_ctrl: table-driven fetch cycles with a bus scoreboard, plus POC, stall/late,
// reset and sync-alignment sequences.
module tb_i4004_bus_ctrl;
  typedef struct {
    logic [3:0] a1, a2, a3;
    logic       cmrom;
    logic [7:0] mdata;
    int         ack_dly;
    logic       exp_req, exp_oe;
    logic [3:0] exp_m1, exp_m2;
    logic       exp_err;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, sync_in = 1'b0, cmrom_in = 1'b0, mem_ack = 1'b0;
  logic [3:0]  cpu_data = 4'h0;
  logic [7:0]  mem_data = 8'h00;
  logic        clk1_out, clk2_out, poc_out, data_oe, mem_req, locked, err;
  logic [3:0]  data_out;
  logic [11:0] mem_addr;
  int          checks = 0, failures = 0;
  int          ack_dly = 1, req_cnt = 0, spur_req = 0, spur_done = 0;
  logic [7:0]  ack_byte = 8'h00;
  logic        auto_ack = 1'b1;
  logic [11:0] req_addr;
  logic [4:0]  sb[$];

  i4004_bus_ctrl #(.DIV(2), .POC_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk1_out(clk1_out), .clk2_out(clk2_out), .poc_out(poc_out),
    .sync_in(sync_in), .cmrom_in(cmrom_in), .cpu_data(cpu_data), .data_out(data_out),
    .data_oe(data_oe), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset();
    chk("rst_clk1", clk1_out, 0);
    chk("rst_clk2", clk2_out, 0);
    chk("rst_poc", poc_out, 1);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
  endtask

  // One instruction cycle starting at A1 seg0; fz = clks the A3 subcycle is stretched.
  task automatic run_cycle(input vec_t v, input int fz);
    int n0 = req_cnt;
    ack_dly  = v.ack_dly;
    ack_byte = v.mdata;
    sb.push_back(v.exp_oe ? {1'b1, v.exp_m1} : 5'd0);
    sb.push_back(v.exp_oe ? {1'b1, v.exp_m2} : 5'd0);
    for (int s = 0; s < 8; s++) begin
      cpu_data = s == 0 ? v.a1 : s == 1 ? v.a2 : s == 2 ? v.a3 : 4'h0;
      cmrom_in = s == 2 ? v.cmrom : 1'b0;
      for (int i = 0; i < 8 + (s == 2 ? fz : 0); i++) begin
        @(posedge clk);
        @(negedge clk);
        if (i == 0) chk("clk1_seg0", clk1_out, 1);
        if (i == 3) chk("bus_drive", {data_oe, data_out}, (s == 3 || s == 4) ? sb.pop_front() : 5'd0);
        if (s == 2 && i >= 6 && fz > 0) chk("stall_clk_low", {clk1_out, clk2_out}, 0);
        if (s == 3 && i == 3) chk("req_in_m1", mem_req, v.exp_req && fz == 0 && v.ack_dly > 6);
      end
    end
    chk("mem_addr", mem_addr, {v.a3, v.a2, v.a1});
    chk("req_issued", req_cnt - n0, v.exp_req);
    chk("err", err, v.exp_err);
  endtask

  // External memory: acks ack_dly clks after mem_req is first seen, or a spurious pulse on request.
  initial begin
    forever begin
      @(negedge clk);
      if (spur_req != spur_done) begin
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        spur_done++;
      end else if (auto_ack && mem_req) begin
        req_cnt++;
        req_addr = mem_addr;
        repeat (ack_dly - 1) @(negedge clk);
        chk("addr_stable", mem_addr, req_addr);
        mem_data = ack_byte;
        mem_ack  = 1'b1;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = 8'h00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    vec_t late_v;
    int   fz;
    tbl[0] = '{4'h4, 4'h3, 4'h2, 1'b1, 8'hD5, 2, 1'b1, 1'b1, 4'hD, 4'h5, 1'b0};
    tbl[1] = '{4'h4, 4'h3, 4'h2, 1'b0, 8'hD5, 2, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[2] = '{4'h1, 4'hF, 4'hA, 1'b1, 8'h3C, 1, 1'b1, 1'b1, 4'h3, 4'hC, 1'b0};
    tbl[3] = '{4'hE, 4'h0, 4'h9, 1'b1, 8'h81, 2, 1'b1, 1'b1, 4'h8, 4'h1, 1'b0};
`ifdef BUS_STALL_EN
    late_v = '{4'h9, 4'h8, 4'h7, 1'b1, 8'hA6, 22, 1'b1, 1'b1, 4'hA, 4'h6, 1'b0};
    fz = 20;
`else
    late_v = '{4'h9, 4'h8, 4'h7, 1'b1, 8'hA6, 22, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    fz = 0;
`endif
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    for (int e = 1; e <= 512; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk("clk1_phase", clk1_out, ((e - 1) % 8) / 2 == 0);
      chk("clk2_phase", clk2_out, ((e - 1) % 8) / 2 == 2);
      chk("clk_overlap", clk1_out & clk2_out, 0);
      chk("poc", poc_out, e < 512);
    end
    for (int k = 0; k < 4; k++) run_cycle(tbl[k], 0);
    run_cycle(late_v, fz);
    // Reset while a request is outstanding, with an ack arriving during reset.
    auto_ack = 1'b0;
    cmrom_in = 1'b1;
    cpu_data = 4'h6;
    adv(22);
    chk("req_before_rst", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    spur_req++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmrom_in = 1'b0;
    adv(3);
    chk("ack_in_rst_ignored", err, 0);
    chk("req_after_rst", mem_req, 0);
    spur_req++;
    adv(3);
    chk("spur_ack_err", err, 1);
    chk("spur_ack_no_req", mem_req, 0);
    rst_n = 1'b0;
    #1 chk("err_async_clr", err, 0);
    chk("poc_async", poc_out, 1);
    @(negedge clk);
    rst_n = 1'b1;
    // Sync alignment: X3 seg2 sample is the 62nd clk after release.
    adv(61);
    sync_in = 1'b1;
    adv(1);
    sync_in = 1'b0;
    chk("lock_x3", locked, 1);
    chk("lock_no_err", err, 0);
    adv(64);
    chk("lock_lost", locked, 0);
    adv(47);
    sync_in = 1'b1;
    adv(1);
    sync_in = 1'b0;
    chk("resync_unlock", locked, 0);
    chk("resync_err", err, 1);
    adv(2);
    chk("jump_x3_clk2", clk2_out, 1);
    adv(3);
    chk("jump_wrap_clk1", clk1_out, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
